// File: rtl/pc_gen_stage.sv
// Purpose : fetch program-counter generator with trap/return/jump redirect and a one-entry pending-redirect buffer.
// Latency : a redirect on an advance cycle (cpu_stat_pc=1) appears on pc the next cycle; a stalled redirect is applied at the next advance.
// Backpres: cpu_stat_pc=0 holds pc; a redirect seen during the stall is buffered (higher rank replaces) rather than dropped.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cpu_start/_adr      - load a start word address at the next advance
//   cpu_stat_pc         - PC advance enable
//   ecall_ex, g_interrupt, g_exception, int_cause, mtvec_mode, csr_mtvec_ex - trap request and vector base
//   mret_ex/sret_ex/uret_ex, csr_mepc_ex/csr_sepc_ex/csr_uepc_ex           - return requests and targets
//   jmp_ex, jmp_adr_ex  - taken branch/jump and target
//   pc, pc_excep        - fetch word address, PC to record in xEPC
//   redirect_pend       - pending buffer occupied
//   redirect_fire       - pulse: pc was loaded from a redirect on the previous edge
module pc_gen_stage #(
  parameter int            AW        = 30,
  parameter logic [AW-1:0] RESET_ADR = '0,
  parameter int            CW        = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_start,
  input  logic [AW-1:0] cpu_start_adr,
  input  logic          cpu_stat_pc,
  input  logic          ecall_ex,
  input  logic          g_interrupt,
  input  logic          g_exception,
  input  logic [CW-1:0] int_cause,
  input  logic          mtvec_mode,
  input  logic [AW-1:0] csr_mtvec_ex,
  input  logic          jmp_ex,
  input  logic          mret_ex,
  input  logic          sret_ex,
  input  logic          uret_ex,
  input  logic [AW-1:0] csr_mepc_ex,
  input  logic [AW-1:0] csr_sepc_ex,
  input  logic [AW-1:0] csr_uepc_ex,
  input  logic [AW-1:0] jmp_adr_ex,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_excep,
  output logic          redirect_pend,
  output logic          redirect_fire
);

  // Encoding doubles as priority: a numerically larger class outranks a smaller one.
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_JMP  = 2'd1,
    CLS_RET  = 2'd2,
    CLS_TRAP = 2'd3
  } cls_e;

  // Vector sum is formed wide enough for either operand, then truncated (mod 2^AW).
  localparam int SW = (AW > CW) ? AW : CW;

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_pend_adr;
  logic [AW-1:0] r_ecall_pc;
  logic          r_start_ld;
  logic          r_pend;
  logic          r_pend_ecall;
  logic          r_fire;
  cls_e          r_pend_cls;

  logic          w_trap;
  logic          w_ret;
  cls_e          w_live_cls;
  logic [SW-1:0] w_vec_sum;
  logic [AW-1:0] w_trap_adr;
  logic [AW-1:0] w_ret_adr;
  logic [AW-1:0] w_live_adr;
  logic [AW-1:0] w_pc_inc;
  logic          w_take_pend;
  logic          w_redir;
  logic [AW-1:0] w_redir_adr;
  logic          w_ecall_cap;
  logic          w_ecall_src;

  always_comb begin
    w_trap     = ecall_ex | g_interrupt | g_exception;
    w_ret      = mret_ex | sret_ex | uret_ex;
    w_vec_sum  = SW'(csr_mtvec_ex) + SW'(int_cause);
    // Only interrupts are vectored; exceptions and ecall always use the base.
    w_trap_adr = (mtvec_mode & g_interrupt) ? w_vec_sum[AW-1:0] : csr_mtvec_ex;
    w_ret_adr  = mret_ex ? csr_mepc_ex : (sret_ex ? csr_sepc_ex : csr_uepc_ex);

    w_live_cls = CLS_NONE;
    w_live_adr = jmp_adr_ex;
    if (w_trap) begin
      w_live_cls = CLS_TRAP;
      w_live_adr = w_trap_adr;
    end else if (w_ret) begin
      w_live_cls = CLS_RET;
      w_live_adr = w_ret_adr;
    end else if (jmp_ex) begin
      w_live_cls = CLS_JMP;
    end

    w_pc_inc    = r_pc + AW'(1);
    // Live wins ties, so the buffer is used only when it strictly outranks.
    w_take_pend = r_pend & (r_pend_cls > w_live_cls);
    w_redir     = r_pend | (w_live_cls != CLS_NONE);
    w_redir_adr = w_take_pend ? r_pend_adr : w_live_adr;

    // A buffered ecall records its PC only when it is actually applied; pc
    // has been frozen since the ecall was seen, so r_pc is still its PC.
    w_ecall_cap = cpu_stat_pc & (ecall_ex | (~r_start_ld & w_take_pend & r_pend_ecall));
    w_ecall_src = ecall_ex | (r_pend & r_pend_ecall);

    // Bypass the value being captured so xEPC sees it in the same cycle.
    if (w_ecall_src & ~g_interrupt & ~g_exception) begin
      pc_excep = w_ecall_cap ? r_pc : r_ecall_pc;
    end else begin
      pc_excep = w_pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_ADR;
      r_start_ld   <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_adr   <= '0;
      r_pend_cls   <= CLS_NONE;
      r_pend_ecall <= 1'b0;
      r_ecall_pc   <= '0;
      r_fire       <= 1'b0;
    end else begin
      r_fire <= 1'b0;
      if (w_ecall_cap) begin
        r_ecall_pc <= r_pc;
      end
      if (cpu_stat_pc) begin
        r_start_ld   <= 1'b0;
        r_pend       <= 1'b0;
        r_pend_cls   <= CLS_NONE;
        r_pend_ecall <= 1'b0;
        if (r_start_ld) begin
          r_pc <= cpu_start_adr;
        end else if (w_redir) begin
          r_pc   <= w_redir_adr;
          r_fire <= 1'b1;
        end else begin
          r_pc <= w_pc_inc;
        end
      end else begin
        if (cpu_start) begin
          r_start_ld <= 1'b1;
        end
        if ((w_live_cls != CLS_NONE) && (!r_pend || (w_live_cls > r_pend_cls))) begin
          r_pend       <= 1'b1;
          r_pend_adr   <= w_live_adr;
          r_pend_cls   <= w_live_cls;
          r_pend_ecall <= ecall_ex;
        end
      end
    end
  end

  assign pc            = r_pc;
  assign redirect_pend = r_pend;
  assign redirect_fire = r_fire;

endmodule

// File: tb/tb_pc_gen_stage.sv
module tb_pc_gen_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cpu_start, cpu_stat_pc;
  logic        ecall_ex, g_interrupt, g_exception, mtvec_mode;
  logic        jmp_ex, mret_ex, sret_ex, uret_ex;
  logic [4:0]  int_cause;
  logic [29:0] cpu_start_adr, csr_mtvec_ex, csr_mepc_ex, csr_sepc_ex, csr_uepc_ex, jmp_adr_ex;

  logic [29:0] pc0, pcx0;
  logic        pend0, fire0;
  logic [3:0]  pc1, pcx1;
  logic        pend1, fire1;

  pc_gen_stage #(.AW(30), .RESET_ADR(30'h100), .CW(5)) u_dut (
    .clk(clk), .rst(rst), .cpu_start(cpu_start), .cpu_start_adr(cpu_start_adr),
    .cpu_stat_pc(cpu_stat_pc), .ecall_ex(ecall_ex), .g_interrupt(g_interrupt),
    .g_exception(g_exception), .int_cause(int_cause), .mtvec_mode(mtvec_mode),
    .csr_mtvec_ex(csr_mtvec_ex), .jmp_ex(jmp_ex), .mret_ex(mret_ex), .sret_ex(sret_ex),
    .uret_ex(uret_ex), .csr_mepc_ex(csr_mepc_ex), .csr_sepc_ex(csr_sepc_ex),
    .csr_uepc_ex(csr_uepc_ex), .jmp_adr_ex(jmp_adr_ex),
    .pc(pc0), .pc_excep(pcx0), .redirect_pend(pend0), .redirect_fire(fire0)
  );

  pc_gen_stage #(.AW(4), .RESET_ADR(4'h3), .CW(5)) u_dut4 (
    .clk(clk), .rst(rst), .cpu_start(cpu_start), .cpu_start_adr(cpu_start_adr[3:0]),
    .cpu_stat_pc(cpu_stat_pc), .ecall_ex(ecall_ex), .g_interrupt(g_interrupt),
    .g_exception(g_exception), .int_cause(int_cause), .mtvec_mode(mtvec_mode),
    .csr_mtvec_ex(csr_mtvec_ex[3:0]), .jmp_ex(jmp_ex), .mret_ex(mret_ex), .sret_ex(sret_ex),
    .uret_ex(uret_ex), .csr_mepc_ex(csr_mepc_ex[3:0]), .csr_sepc_ex(csr_sepc_ex[3:0]),
    .csr_uepc_ex(csr_uepc_ex[3:0]), .jmp_adr_ex(jmp_adr_ex[3:0]),
    .pc(pc1), .pc_excep(pcx1), .redirect_pend(pend1), .redirect_fire(fire1)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit m_valid  = 1'b0;

  // Reference state per instance: index 0 = AW 30, index 1 = AW 4.
  logic [29:0] m_pc[2], m_padr[2], m_epc[2];
  bit          m_start[2], m_pend[2], m_pecall[2], m_fire[2];
  int          m_prank[2];
  logic [29:0] n_pc[2], n_padr[2], n_epc[2];
  bit          n_start[2], n_pend[2], n_pecall[2], n_fire[2];
  int          n_prank[2];

  function automatic logic [29:0] amask(int k);
    return (k == 0) ? 30'h3FFF_FFFF : 30'h0000_000F;
  endfunction

  function automatic logic [29:0] rst_val(int k);
    return (k == 0) ? 30'h100 : 30'h3;
  endfunction

  // Rank: trap 3, return 2, jump 1, nothing 0.
  function automatic int live_rank();
    if (ecall_ex || g_interrupt || g_exception) return 3;
    if (mret_ex || sret_ex || uret_ex) return 2;
    if (jmp_ex) return 1;
    return 0;
  endfunction

  function automatic logic [29:0] live_tgt(int k);
    logic [29:0] m;
    m = amask(k);
    if (ecall_ex || g_interrupt || g_exception) begin
      if (mtvec_mode && g_interrupt) return (csr_mtvec_ex + {25'd0, int_cause}) & m;
      return csr_mtvec_ex & m;
    end
    if (mret_ex) return csr_mepc_ex & m;
    if (sret_ex) return csr_sepc_ex & m;
    if (uret_ex) return csr_uepc_ex & m;
    return jmp_adr_ex & m;
  endfunction

  function automatic logic [29:0] exp_excep(int k);
    bit take_pend, cap, src;
    take_pend = m_pend[k] && (m_prank[k] > live_rank());
    cap = cpu_stat_pc && (ecall_ex || (!m_start[k] && take_pend && m_pecall[k]));
    src = ecall_ex || (m_pend[k] && m_pecall[k]);
    if (src && !g_interrupt && !g_exception) return cap ? m_pc[k] : m_epc[k];
    return (m_pc[k] + 30'd1) & amask(k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_next(int k);
    int lr;
    bit take_pend;
    lr = live_rank();
    n_pc[k] = m_pc[k]; n_padr[k] = m_padr[k]; n_epc[k] = m_epc[k];
    n_start[k] = m_start[k]; n_pend[k] = m_pend[k]; n_pecall[k] = m_pecall[k];
    n_prank[k] = m_prank[k]; n_fire[k] = 1'b0;
    if (rst) begin
      n_pc[k] = rst_val(k); n_padr[k] = '0; n_epc[k] = '0;
      n_start[k] = 0; n_pend[k] = 0; n_pecall[k] = 0; n_prank[k] = 0;
    end else if (cpu_stat_pc) begin
      take_pend = m_pend[k] && (m_prank[k] > lr);
      if (ecall_ex || (!m_start[k] && take_pend && m_pecall[k])) n_epc[k] = m_pc[k];
      n_start[k] = 0; n_pend[k] = 0; n_pecall[k] = 0; n_prank[k] = 0;
      if (m_start[k]) n_pc[k] = cpu_start_adr & amask(k);
      else if (lr > 0 || m_pend[k]) begin
        n_pc[k] = take_pend ? m_padr[k] : live_tgt(k);
        n_fire[k] = 1'b1;
      end else n_pc[k] = (m_pc[k] + 30'd1) & amask(k);
    end else begin
      if (cpu_start) n_start[k] = 1'b1;
      if (lr > 0 && (!m_pend[k] || lr > m_prank[k])) begin
        n_pend[k] = 1'b1; n_padr[k] = live_tgt(k); n_prank[k] = lr; n_pecall[k] = ecall_ex;
      end
    end
  endtask

  // One clock: check combinational output, advance model and DUT, check registered outputs.
  task automatic step();
    #1;
    if (m_valid) begin
      chk("pc_excep[0]", {2'b0, pcx0}, {2'b0, exp_excep(0)});
      chk("pc_excep[1]", {28'b0, pcx1}, {2'b0, exp_excep(1)});
    end
    for (int k = 0; k < 2; k++) model_next(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = n_pc[k]; m_padr[k] = n_padr[k]; m_epc[k] = n_epc[k];
      m_start[k] = n_start[k]; m_pend[k] = n_pend[k]; m_pecall[k] = n_pecall[k];
      m_prank[k] = n_prank[k]; m_fire[k] = n_fire[k];
    end
    if (rst) m_valid = 1'b1;
    if (m_valid) begin
      chk("pc[0]",   {2'b0, pc0},   {2'b0, m_pc[0]});
      chk("pend[0]", {31'b0, pend0}, {31'b0, m_pend[0]});
      chk("fire[0]", {31'b0, fire0}, {31'b0, m_fire[0]});
      chk("pc[1]",   {28'b0, pc1},  {2'b0, m_pc[1]});
      chk("pend[1]", {31'b0, pend1}, {31'b0, m_pend[1]});
      chk("fire[1]", {31'b0, fire1}, {31'b0, m_fire[1]});
    end
  endtask

  task automatic clr_in();
    cpu_start = 0; ecall_ex = 0; g_interrupt = 0; g_exception = 0; mtvec_mode = 0;
    jmp_ex = 0; mret_ex = 0; sret_ex = 0; uret_ex = 0; int_cause = '0;
    cpu_start_adr = '0; csr_mtvec_ex = '0; csr_mepc_ex = '0; csr_sepc_ex = '0;
    csr_uepc_ex = '0; jmp_adr_ex = '0;
  endtask

  task automatic load_pc(input logic [29:0] adr);
    clr_in(); cpu_stat_pc = 0; cpu_start = 1; cpu_start_adr = adr; step();
    cpu_start = 0; cpu_stat_pc = 1; step();
  endtask

  initial begin
    clr_in();
    rst = 1; cpu_stat_pc = 0;
    @(posedge clk); #1;
    step();
    chk("reset_pc", {2'b0, pc0}, 32'h100);
    chk("reset_pend", {31'b0, pend0}, 32'h0);
    chk("reset_fire", {31'b0, fire0}, 32'h0);
    rst = 0;

    // start then three advances
    cpu_start = 1; cpu_start_adr = 30'h40; step();
    chk("start_held", {2'b0, pc0}, 32'h100);
    cpu_start = 0; cpu_stat_pc = 1; step();
    chk("start_pc", {2'b0, pc0}, 32'h40);
    step(); chk("adv1", {2'b0, pc0}, 32'h41);
    step(); chk("adv2", {2'b0, pc0}, 32'h42);

    // stalled jump is buffered then applied
    load_pc(30'h1F);
    cpu_stat_pc = 0; jmp_ex = 1; jmp_adr_ex = 30'h80; step();
    chk("jmp_pend", {31'b0, pend0}, 32'h1);
    chk("jmp_hold", {2'b0, pc0}, 32'h1F);
    jmp_ex = 0; cpu_stat_pc = 1; step();
    chk("jmp_pc", {2'b0, pc0}, 32'h80);
    chk("jmp_fire", {31'b0, fire0}, 32'h1);
    chk("jmp_pend_clr", {31'b0, pend0}, 32'h0);
    cpu_stat_pc = 0; step();
    chk("fire_pulse", {31'b0, fire0}, 32'h0);

    // interrupt replaces a buffered jump: vectored, then direct
    for (int mode = 1; mode >= 0; mode--) begin
      clr_in(); cpu_stat_pc = 0; jmp_ex = 1; jmp_adr_ex = 30'h80; step();
      jmp_ex = 0; g_interrupt = 1; csr_mtvec_ex = 30'h200; mtvec_mode = mode[0]; int_cause = 5'd7; step();
      g_interrupt = 0; cpu_stat_pc = 1; step();
      chk("irq_pc", {2'b0, pc0}, (mode == 1) ? 32'h207 : 32'h200);
    end

    // buffered trap beats a live mret
    clr_in(); cpu_stat_pc = 0; g_exception = 1; csr_mtvec_ex = 30'h200; step();
    g_exception = 0; cpu_stat_pc = 1; mret_ex = 1; csr_mepc_ex = 30'h55; step();
    chk("trap_over_mret", {2'b0, pc0}, 32'h200);
    sret_ex = 1; csr_sepc_ex = 30'h66; step();
    chk("mret_over_sret", {2'b0, pc0}, 32'h55);
    mret_ex = 0; sret_ex = 0; uret_ex = 1; csr_uepc_ex = 30'h33; step();
    chk("uret", {2'b0, pc0}, 32'h33);

    // ecall PC capture
    load_pc(30'h10);
    clr_in(); ecall_ex = 1; csr_mtvec_ex = 30'h200; #1;
    chk("ecall_excep", {2'b0, pcx0}, 32'h10);
    step();
    chk("ecall_pc", {2'b0, pc0}, 32'h200);
    load_pc(30'h10);
    clr_in(); ecall_ex = 1; g_exception = 1; csr_mtvec_ex = 30'h200; #1;
    chk("ecall_exc_excep", {2'b0, pcx0}, 32'h11);
    step();

    // narrow instance wrap and vector wrap
    load_pc(30'hF);
    clr_in(); step();
    chk("aw4_wrap", {28'b0, pc1}, 32'h0);
    g_interrupt = 1; mtvec_mode = 1; csr_mtvec_ex = 30'hE; int_cause = 5'd3; step();
    chk("aw4_vec_wrap", {28'b0, pc1}, 32'h1);

    // reset while a redirect is buffered and advance is high
    clr_in(); cpu_stat_pc = 0; jmp_ex = 1; jmp_adr_ex = 30'h5; step();
    chk("aw4_pend", {31'b0, pend1}, 32'h1);
    jmp_ex = 0; rst = 1; cpu_stat_pc = 1; step();
    chk("rst_pend", {31'b0, pend1}, 32'h0);
    chk("rst_pc4", {28'b0, pc1}, 32'h3);
    chk("rst_pc", {2'b0, pc0}, 32'h100);
    rst = 0;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      cpu_stat_pc   = $urandom_range(0, 1);
      cpu_start     = ($urandom_range(0, 9) == 0);
      ecall_ex      = ($urandom_range(0, 9) == 0);
      g_interrupt   = ($urandom_range(0, 9) == 0);
      g_exception   = ($urandom_range(0, 11) == 0);
      jmp_ex        = ($urandom_range(0, 3) == 0);
      mret_ex       = ($urandom_range(0, 9) == 0);
      sret_ex       = ($urandom_range(0, 9) == 0);
      uret_ex       = ($urandom_range(0, 9) == 0);
      mtvec_mode    = $urandom_range(0, 1);
      int_cause     = 5'($urandom);
      cpu_start_adr = 30'($urandom);
      csr_mtvec_ex  = 30'($urandom);
      csr_mepc_ex   = 30'($urandom);
      csr_sepc_ex   = 30'($urandom);
      csr_uepc_ex   = 30'($urandom);
      jmp_adr_ex    = 30'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen_stage.md
Name: pc_gen_stage

Overview:
- Parametrised next-generation program-counter stage for the RV32I core; drives the word-addressed fetch PC.
- Adds to the existing PC-stage function:
  - configurable address width and reset vector;
  - vectored trap entry;
  - a uret return path;
  - a one-entry pending-redirect buffer, so a redirect raised while the PC is not advancing is applied later instead of being lost.
- Sits ahead of the fetch stage; takes redirect requests from EX and CSR values from the CSR file.

Parameters:
AW, 30, PC word-address width (PC byte address bits [AW+1:2]).
RESET_ADR, 0, PC value loaded by reset (AW bits).
CW, 5, interrupt cause width used for vectored offset.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_start  in  1  request to load start address at next advance
cpu_start_adr  in  AW  start word address
cpu_stat_pc  in  1  PC advance enable (PC state of CPU sequencer)
ecall_ex  in  1  ecall in EX
g_interrupt  in  1  interrupt taken
g_exception  in  1  exception taken
int_cause  in  CW  interrupt cause number
mtvec_mode  in  1  1 = vectored, 0 = direct
csr_mtvec_ex  in  AW  trap base word address
jmp_ex  in  1  taken branch/jump
mret_ex / sret_ex / uret_ex  in  1 each  return instructions
csr_mepc_ex / csr_sepc_ex / csr_uepc_ex  in  AW each  return targets
jmp_adr_ex  in  AW  branch/jump target
pc  out  AW  current fetch word address
pc_excep  out  AW  PC to write to xEPC
redirect_pend  out  1  pending-redirect buffer occupied
redirect_fire  out  1  one-cycle pulse: PC loaded from a redirect this cycle

Behaviour:
Reset, checked on the clk edge with rst=1:
- pc=RESET_ADR; start_ld=0; pend=0; pend_adr=0; pend_cls=0; ecall_pc=0; redirect_fire=0.

Redirect classes:
- trap = ecall_ex|g_interrupt|g_exception.
- ret = mret|sret|uret.
- jmp = jmp_ex.
- Rank: trap > ret > jmp.

Live target (combinational):
- trap, direct mode: csr_mtvec_ex.
- trap, vectored (mtvec_mode=1 and g_interrupt=1): csr_mtvec_ex + zero-extended int_cause, modulo 2^AW.
- Within ret: mret > sret > uret, giving mepc / sepc / uepc.
- Else: jmp_adr_ex.

start_ld flag:
- Set by cpu_start.
- Cleared on any cycle with cpu_stat_pc=1; the clear has priority over a simultaneous set.

Pending buffer, when cpu_stat_pc=0 and a live redirect is present:
- If pend=0, capture the live target and class; pend=1.
- If pend=1, replace only when the live class outranks pend_cls; otherwise hold.

PC update when cpu_stat_pc=1, first match wins:
1. start_ld: pc=cpu_start_adr, pend cleared.
2. Select the higher-ranked of live and pending; on equal class, live wins. pc=that target, pend cleared, redirect_fire=1 next cycle.
3. Otherwise pc=pc+1, wrapping modulo 2^AW.

Stall behaviour:
- When cpu_stat_pc=0, pc holds.
- The pending buffer is not cleared by cpu_stat_pc=0.

ecall capture:
- ecall_pc<=pc when ecall_ex & cpu_stat_pc.
- If pend holds a trap that came from an ecall, capture happens when that trap is applied.

pc_excep (combinational):
- ecall_pc when ecall is the effective trap source and neither g_interrupt nor g_exception is present.
- Otherwise pc+1 (mod 2^AW).

Reset mid-operation:
- rst overrides everything: start, pending buffer, stall.
- Reset with cpu_stat_pc=1 still yields pc=RESET_ADR.

Latency:
- Redirect applied in the same cycle as cpu_stat_pc, so it is visible on pc the next cycle.
- A buffered redirect is applied at the first subsequent cpu_stat_pc=1 cycle.

Test Plan:
- Reset with RESET_ADR=0x100, then cpu_start with adr=0x40, then 3 advance pulses -> pc sequence 0x100, 0x40, 0x41, 0x42; start_ld clears.
- pc=0x1F and jmp_ex with adr=0x80 while cpu_stat_pc=0 -> redirect_pend=1 and pc holds; next advance -> pc=0x80, redirect_fire pulse, pend=0.
- Pending jmp to 0x80, then g_interrupt arrives during the stall with mtvec=0x200, mode=1, cause=7 -> pend replaced; advance gives pc=0x207. Same scenario with mode=0 -> pc=0x200.
- Pending trap, then live mret (mepc=0x55) on the advance cycle -> trap wins, pc=mtvec. mret and sret asserted together -> pc=mepc. uret alone with uepc=0x33 -> pc=0x33.
- ecall at pc=0x10 with advance -> ecall_pc=0x10, pc_excep=0x10. Same cycle with g_exception=1 -> pc_excep=0x11.
- AW=4 wrap: pc=0xF, advance -> 0x0; vectored 0xE+cause 3 -> 0x1. Assert rst while pend=1 -> pend=0, pc=RESET_ADR.
